// File: rtl/imem_load_ctrl_if.sv
// Program-memory port shared by the fetch stage and the UART loader.
// The controller drives the port (master); the memory samples it (slave).
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;

    modport master (output mem_addr, output mem_wdata, output mem_we);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_we);
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: packs UART bytes little-endian into words,
// writes them to program memory while holding the CPU in reset, then hands the port back to fetch.
// The rx stream has no back-pressure: a byte is taken on every clock where rx_valid is high
// and the controller is in ARM, RECV or WRITE; bytes in any other state are dropped.
module imem_load_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_load,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [ADDR_W-1:0] fetch_addr,
    imem_load_ctrl_if.master  mem,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic [2:0]        dbg_state
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] CAP        = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_ARM   = 3'd1,
        S_RECV  = 3'd2,
        S_WRITE = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wreg_q, wreg_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              ovf_q, ovf_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              byte_accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            wreg_q      <= '0;
            wptr_q      <= '0;
            wc_q        <= '0;
            ovf_q       <= 1'b0;
            timer_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            wreg_q      <= wreg_d;
            wptr_q      <= wptr_d;
            wc_q        <= wc_d;
            ovf_q       <= ovf_d;
            timer_q     <= timer_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
        end
    end

    assign byte_accept = rx_valid &&
                         (state_q == S_ARM || state_q == S_RECV || state_q == S_WRITE);

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        wreg_d      = wreg_q;
        wptr_d      = wptr_q;
        wc_d        = wc_q;
        ovf_d       = ovf_q;
        timer_d     = timer_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        load_done_d = 1'b0;
        cpu_hold_d  = (state_q != S_RUN);

        // Pointers advance while the registered write is on the bus, so mem_addr stays stable.
        if (mem_we_q) begin
            wptr_d = wptr_q + 1'b1;
            wc_d   = wc_q + 1'b1;
        end

        if (byte_accept) begin
            timer_d = '0;
            asm_d[8*byte_idx_q +: 8] = rx_byte;
            if (byte_idx_q == 2'd3) begin
                wreg_d     = {rx_byte, asm_q[23:0]};
                asm_d      = '0;
                byte_idx_d = 2'd0;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end

        case (state_q)
            S_RUN: begin
                if (start_load) begin
                    state_d    = S_ARM;
                    wptr_d     = '0;
                    wc_d       = '0;
                    byte_idx_d = '0;
                    asm_d      = '0;
                    ovf_d      = 1'b0;
                    timer_d    = '0;
                end
            end
            S_ARM: begin
                if (byte_accept) state_d = S_RECV;
            end
            S_RECV: begin
                if (byte_accept) begin
                    if (byte_idx_q == 2'd3) state_d = S_WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WRITE: begin
                if (wc_q == CAP) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wreg_q;
                end
                if (!byte_accept) timer_d = timer_q + TW'(1);
                state_d = S_RECV;
            end
            S_FLUSH: begin
                // Unfilled upper lanes are already zero: asm is cleared after every full word.
                if (byte_idx_q != 2'd0) begin
                    if (wc_q == CAP) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = asm_q;
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                load_done_d = 1'b1;
                state_d     = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign mem.mem_addr  = (state_q == S_RUN) ? fetch_addr : wptr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = load_done_q;
    assign word_count    = wc_q;
    assign overflow      = ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a 16 KW instance and a 4-word instance share all inputs.
module tb_imem_load_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_load = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic [13:0] fetch_addr = 14'h0123;

    logic        cpu_hold_a, load_done_a, overflow_a;
    logic [14:0] word_count_a;
    logic [2:0]  dbg_a;
    logic        cpu_hold_b, load_done_b, overflow_b;
    logic [2:0]  word_count_b;
    logic [2:0]  dbg_b;

    logic [63:0] exp_q[$];
    logic [63:0] obs_a[$];
    logic [63:0] obs_b[$];
    int n_vec = 0;
    int n_err = 0;
    int k;

    imem_load_ctrl_if #(.ADDR_W(14)) if_a ();
    imem_load_ctrl_if #(.ADDR_W(2))  if_b ();

    imem_load_ctrl #(.ADDR_W(14), .TIMEOUT(16)) dut_a (
        .clock(clk), .reset_n(rst_n), .start_load(start_load), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .fetch_addr(fetch_addr), .mem(if_a.master),
        .cpu_hold(cpu_hold_a), .load_done(load_done_a), .word_count(word_count_a),
        .overflow(overflow_a), .dbg_state(dbg_a)
    );

    imem_load_ctrl #(.ADDR_W(2), .TIMEOUT(16)) dut_b (
        .clock(clk), .reset_n(rst_n), .start_load(start_load), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .fetch_addr(fetch_addr[1:0]), .mem(if_b.master),
        .cpu_hold(cpu_hold_b), .load_done(load_done_b), .word_count(word_count_b),
        .overflow(overflow_b), .dbg_state(dbg_b)
    );

    // clock / write capture
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_a.mem_we) obs_a.push_back({32'(if_a.mem_addr), if_a.mem_wdata});
        if (if_b.mem_we) obs_b.push_back({32'(if_b.mem_addr), if_b.mem_wdata});
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = '0;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        obs_a.delete();
        obs_b.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (load_done_a) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) chk("load_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_writes_a();
        chk("a_write_count", 64'(obs_a.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("a_write", (i < obs_a.size()) ? obs_a[i] : 64'hx, exp_q[i]);
        obs_a.delete();
        exp_q.delete();
    endtask

    task automatic check_writes_b();
        chk("b_write_count", 64'(obs_b.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("b_write", (i < obs_b.size()) ? obs_b[i] : 64'hx, exp_q[i]);
        obs_b.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_mem_addr", 64'(if_a.mem_addr), 64'h0123);
        chk("rst_cpu_hold", 64'(cpu_hold_a), 64'd0);
        chk("rst_mem_we", 64'(if_a.mem_we), 64'd0);
        chk("rst_wdata", 64'(if_a.mem_wdata), 64'd0);
        chk("rst_load_done", 64'(load_done_a), 64'd0);
        chk("rst_word_count", 64'(word_count_a), 64'd0);
        chk("rst_overflow", 64'(overflow_a), 64'd0);
        chk("rst_state", 64'(dbg_a), 64'd0);
        do_reset();
        fetch_addr = 14'h0456;
        #1;
        chk("run_addr_follow", 64'(if_a.mem_addr), 64'h0456);

        // two full words with idle gaps, timeout ends the load
        pulse_start();
        chk("hold_not_yet", 64'(cpu_hold_a), 64'd0);
        chk("state_arm", 64'(dbg_a), 64'd1);
        tick();
        chk("hold_high", 64'(cpu_hold_a), 64'd1);
        chk("arm_addr_wptr", 64'(if_a.mem_addr), 64'd0);
        send_byte(8'h78); tick();
        send_byte(8'h56); tick();
        send_byte(8'h34); tick();
        send_byte(8'h12);
        chk("we_not_yet", 64'(if_a.mem_we), 64'd0);
        chk("state_write", 64'(dbg_a), 64'd3);
        tick();
        chk("we_high", 64'(if_a.mem_we), 64'd1);
        chk("we_addr", 64'(if_a.mem_addr), 64'd0);
        chk("we_data", 64'(if_a.mem_wdata), 64'h12345678);
        chk("wc_before", 64'(word_count_a), 64'd0);
        tick();
        chk("wc_after", 64'(word_count_a), 64'd1);
        chk("we_low", 64'(if_a.mem_we), 64'd0);
        chk("wdata_idle", 64'(if_a.mem_wdata), 64'd0);
        send_byte(8'hEF); tick();
        send_byte(8'hBE); tick();
        send_byte(8'hAD); tick();
        send_byte(8'hDE);
        wait_done(k);
        chk("done_latency", 64'(k), 64'd18);
        chk("done_hold", 64'(cpu_hold_a), 64'd1);
        chk("done_wc", 64'(word_count_a), 64'd2);
        tick();
        chk("done_pulse_end", 64'(load_done_a), 64'd0);
        chk("hold_released", 64'(cpu_hold_a), 64'd0);
        chk("run_again", 64'(dbg_a), 64'd0);
        chk("fetch_owns_port", 64'(if_a.mem_addr), 64'h0456);
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'hDEADBEEF});
        check_writes_a();

        // partial word flush; a byte on the timeout edge wins
        pulse_start();
        tick();
        send_byte(8'hAA);
        send_byte(8'hBB);
        for (int i = 0; i < 15; i++) tick();
        chk("at_limit_recv", 64'(dbg_a), 64'd2);
        send_byte(8'hCC);
        chk("byte_wins", 64'(dbg_a), 64'd2);
        wait_done(k);
        chk("flush_latency", 64'(k), 64'd18);
        chk("flush_wc", 64'(word_count_a), 64'd1);
        tick();
        exp_q.push_back({32'd0, 32'h00CCBBAA});
        check_writes_a();

        // back-to-back bytes: 5th byte lands in the WRITE cycle
        pulse_start();
        tick();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done(k);
        chk("b2b_wc", 64'(word_count_a), 64'd2);
        tick();
        exp_q.push_back({32'd0, 32'h04030201});
        exp_q.push_back({32'd1, 32'h08070605});
        check_writes_a();

        // capacity overflow on the 4-word instance
        do_reset();
        pulse_start();
        tick();
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        wait_done(k);
        chk("ovf_flag", 64'(overflow_b), 64'd1);
        chk("ovf_wc", 64'(word_count_b), 64'd4);
        chk("ovf_big_wc", 64'(word_count_a), 64'd5);
        chk("no_ovf_big", 64'(overflow_a), 64'd0);
        tick();
        chk("ovf_sticky_run", 64'(overflow_b), 64'd1);
        exp_q.push_back({32'd0, 32'h03020100});
        exp_q.push_back({32'd1, 32'h07060504});
        exp_q.push_back({32'd2, 32'h0B0A0908});
        exp_q.push_back({32'd3, 32'h0F0E0D0C});
        check_writes_b();
        obs_a.delete();
        pulse_start();
        chk("ovf_cleared", 64'(overflow_b), 64'd0);
        chk("ovf_wc_cleared", 64'(word_count_b), 64'd0);

        // reset mid-load
        do_reset();
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i));
        chk("mid_we_high", 64'(if_a.mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(if_a.mem_we), 64'd0);
        chk("rst_mid_hold", 64'(cpu_hold_a), 64'd0);
        chk("rst_mid_state", 64'(dbg_a), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        chk("ignore_rx_state", 64'(dbg_a), 64'd0);
        chk("ignore_rx_we", 64'(if_a.mem_we), 64'd0);
        chk("ignore_rx_hold", 64'(cpu_hold_a), 64'd0);
        chk("ignore_rx_wc", 64'(word_count_a), 64'd0);
        chk("ignore_rx_writes", 64'(obs_a.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
